// File: rtl/iram_pkg.sv
// Shared types and constants for the loadable instruction memory.
// State encoding, HALT fill word and a width helper.
package iram_pkg;

    typedef enum logic {
        LOAD = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam logic [15:0] HALT_WORD = 16'h0000;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/iram_loadable_if.sv
// Program load stream: loader is master, instruction memory is slave.
// A word moves on a clock edge where LD_VALID and LD_READY are both high.
interface iram_loadable_if #(
    parameter int DATA_W = 16
);

    logic              LD_VALID;
    logic [DATA_W-1:0] LD_DATA;
    logic              LD_LAST;
    logic              LD_READY;

    modport master (
        output LD_VALID,
        output LD_DATA,
        output LD_LAST,
        input  LD_READY
    );

    modport slave (
        input  LD_VALID,
        input  LD_DATA,
        input  LD_LAST,
        output LD_READY
    );

endinterface

// File: rtl/iram_load_ctrl.sv
// Load/run sequencing for the instruction memory: FSM, word count,
// load handshake, and the write strobe/index into the array.
module iram_load_ctrl
    import iram_pkg::*;
#(
    parameter int DEPTH = 128,
    parameter int CW    = clog2(DEPTH + 1),
    parameter int IW    = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          ld_valid,
    input  logic          ld_last,
    input  logic          reload,
    output logic          ld_ready,
    output logic          run_ready,
    output logic [CW-1:0] word_count,
    output logic          we,
    output logic [IW-1:0] widx
);

    state_t state;
    logic   accept;
    logic   full_next;

    // RELOAD wins over a word offered on the same edge.
    assign accept    = ld_valid & ld_ready & ~reload & (state == LOAD);
    assign full_next = (word_count == CW'(DEPTH - 1));

    assign we   = accept;
    assign widx = word_count[IW-1:0];

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state      <= LOAD;
            word_count <= '0;
            ld_ready   <= 1'b1;
            run_ready  <= 1'b0;
        end else begin
            unique case (state)
                LOAD: begin
                    if (reload) begin
                        word_count <= '0;
                    end else if (accept) begin
                        word_count <= word_count + CW'(1);
                        if (ld_last || full_next) begin
                            state     <= RUN;
                            ld_ready  <= 1'b0;
                            run_ready <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (reload) begin
                        state      <= LOAD;
                        word_count <= '0;
                        ld_ready   <= 1'b1;
                        run_ready  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/iram_loadable.sv
// Streamed-in instruction memory with a combinational fetch port.
// Words past the loaded program or past DEPTH read as FILL_WORD.
module iram_loadable
    import iram_pkg::*;
#(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 8,
    parameter int                DEPTH     = 128,
    parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(HALT_WORD)
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [ADDR_W-1:0]             ADDR,
    output logic [DATA_W-1:0]             Q,
    output logic                          MISALIGN,
    output logic                          OOR,
    iram_loadable_if.slave                ld,
    input  logic                          RELOAD,
    output logic                          RUN_READY,
    output logic [clog2(DEPTH+1)-1:0]     WORD_COUNT
);

    localparam int CW  = clog2(DEPTH + 1);
    localparam int IW  = (DEPTH > 1) ? clog2(DEPTH) : 1;
    localparam int AW1 = ADDR_W - 1;
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];

    logic          ld_ready;
    logic          run_ready;
    logic [CW-1:0] word_count;
    logic          we;
    logic [IW-1:0] widx;

    logic [AW1-1:0] idx;
    logic [31:0]    idx_w;
    logic [31:0]    cnt_w;
    logic           in_range;
    logic           loaded;

    iram_load_ctrl #(
        .DEPTH (DEPTH),
        .CW    (CW),
        .IW    (IW)
    ) u_ctrl (
        .CLK        (CLK),
        .RESET      (RESET),
        .ld_valid   (ld.LD_VALID),
        .ld_last    (ld.LD_LAST),
        .reload     (RELOAD),
        .ld_ready   (ld_ready),
        .run_ready  (run_ready),
        .word_count (word_count),
        .we         (we),
        .widx       (widx)
    );

    assign ld.LD_READY = ld_ready;
    assign RUN_READY   = run_ready;
    assign WORD_COUNT  = word_count;

    // Array is deliberately unreset; word_count masks stale contents.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[widx] <= ld.LD_DATA;
        end
    end

    assign idx      = ADDR[ADDR_W-1:1];
    assign idx_w    = 32'(idx);
    assign cnt_w    = 32'(word_count);
    assign in_range = (idx_w < DEPTH_U);
    assign loaded   = (idx_w < cnt_w);

    assign MISALIGN = run_ready & ADDR[0];
    assign OOR      = run_ready & ~in_range;

    always_comb begin
        Q = FILL_WORD;
        if (run_ready && in_range && loaded) begin
            Q = mem[idx[IW-1:0]];
        end
    end

endmodule

// File: tb/tb_iram_loadable.sv
// Bench for iram_loadable: DEPTH=128 and DEPTH=64 instances,
// fetch expectations queued at drive time and popped at sample time.
module tb_iram_loadable;

    typedef struct {
        logic [15:0] q;
        logic        mis;
        logic        oor;
        logic [7:0]  addr;
    } exp_t;

    logic CLK = 1'b0;
    logic RESET;

    logic [7:0]  addr128, addr64;
    logic        reload128, reload64;
    logic [15:0] q128, q64;
    logic        mis128, mis64, oor128, oor64, rr128, rr64;
    logic [7:0]  wc128;
    logic [6:0]  wc64;

    iram_loadable_if #(.DATA_W(16)) ld128 ();
    iram_loadable_if #(.DATA_W(16)) ld64 ();

    iram_loadable #(
        .DATA_W(16), .ADDR_W(8), .DEPTH(128), .FILL_WORD(16'h0000)
    ) u128 (
        .CLK(CLK), .RESET(RESET), .ADDR(addr128), .Q(q128),
        .MISALIGN(mis128), .OOR(oor128), .ld(ld128),
        .RELOAD(reload128), .RUN_READY(rr128), .WORD_COUNT(wc128)
    );

    iram_loadable #(
        .DATA_W(16), .ADDR_W(8), .DEPTH(64), .FILL_WORD(16'h0000)
    ) u64 (
        .CLK(CLK), .RESET(RESET), .ADDR(addr64), .Q(q64),
        .MISALIGN(mis64), .OOR(oor64), .ld(ld64),
        .RELOAD(reload64), .RUN_READY(rr64), .WORD_COUNT(wc64)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] m128 [128];
    logic [15:0] m64  [64];
    int          cnt128, cnt64;
    bit          run128, run64;
    exp_t        exp_q [$];

    // Reference model of one fetch, queued for later comparison.
    task automatic drive_fetch(input bit big, input logic [7:0] a);
        exp_t e;
        int   idx;
        idx    = int'(a[7:1]);
        e.addr = a;
        if (big) begin
            addr128 = a;
            e.mis = run128 & a[0];
            e.oor = run128 && (idx >= 128);
            e.q   = (run128 && idx < cnt128 && idx < 128) ? m128[idx] : 16'h0000;
        end else begin
            addr64 = a;
            e.mis = run64 & a[0];
            e.oor = run64 && (idx >= 64);
            e.q   = (run64 && idx < cnt64 && idx < 64) ? m64[idx] : 16'h0000;
        end
        exp_q.push_back(e);
    endtask

    task automatic load_word(input bit big, input logic [15:0] d, input bit last);
        if (big) begin
            ld128.LD_VALID = 1'b1;
            ld128.LD_DATA  = d;
            ld128.LD_LAST  = last;
            if (!run128) begin
                m128[cnt128] = d;
                cnt128++;
                if (last || cnt128 == 128) run128 = 1'b1;
            end
        end else begin
            ld64.LD_VALID = 1'b1;
            ld64.LD_DATA  = d;
            ld64.LD_LAST  = last;
            if (!run64) begin
                m64[cnt64] = d;
                cnt64++;
                if (last || cnt64 == 64) run64 = 1'b1;
            end
        end
        @(posedge CLK);
        #1;
        ld128.LD_VALID = 1'b0;
        ld128.LD_LAST  = 1'b0;
        ld64.LD_VALID  = 1'b0;
        ld64.LD_LAST   = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        addr128 = 8'h05;
        addr64  = 8'h05;
        #12;
        n_cmp++;
        if (wc128 !== 8'd0) begin
            n_bad++; $display("FAIL reset_wc got %0d want 0", wc128);
        end
        n_cmp++;
        if (ld128.LD_READY !== 1'b1) begin
            n_bad++; $display("FAIL reset_ldready got %b want 1", ld128.LD_READY);
        end
        n_cmp++;
        if (rr128 !== 1'b0) begin
            n_bad++; $display("FAIL reset_runready got %b want 0", rr128);
        end
        n_cmp++;
        if ({q128, mis128, oor128} !== 18'h0) begin
            n_bad++;
            $display("FAIL reset_fetch got q=%h mis=%b oor=%b want 0/0/0",
                     q128, mis128, oor128);
        end
        n_cmp++;
        if (wc64 !== 7'd0 || ld64.LD_READY !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_u64 got wc=%0d rdy=%b want 0/1", wc64, ld64.LD_READY);
        end
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic test_small_load();
        load_word(1'b1, 16'hF001, 1'b0);
        load_word(1'b1, 16'h0001, 1'b0);
        n_cmp++;
        if (rr128 !== 1'b0 || wc128 !== 8'd2) begin
            n_bad++;
            $display("FAIL small_mid got rr=%b wc=%0d want 0/2", rr128, wc128);
        end
        load_word(1'b1, 16'h20BA, 1'b1);
        n_cmp++;
        if (rr128 !== 1'b1 || wc128 !== 8'd3 || ld128.LD_READY !== 1'b0) begin
            n_bad++;
            $display("FAIL small_done got rr=%b wc=%0d rdy=%b want 1/3/0",
                     rr128, wc128, ld128.LD_READY);
        end
        drive_fetch(1'b1, 8'h04);
        #1;
        n_cmp++;
        if (q128 !== 16'h20BA || mis128 !== 1'b0) begin
            n_bad++;
            $display("FAIL small_q04 got q=%h mis=%b want 20ba/0", q128, mis128);
        end
        void'(exp_q.pop_front());
        foreach (exp_q[i]) exp_q.delete(i);
        begin
            logic [7:0] al [4];
            al = '{8'h06, 8'h05, 8'h00, 8'h02};
            foreach (al[i]) begin
                exp_t e;
                drive_fetch(1'b1, al[i]);
                #1;
                e = exp_q.pop_front();
                n_cmp++;
                if (q128 !== e.q || mis128 !== e.mis || oor128 !== e.oor) begin
                    n_bad++;
                    $display("FAIL small_fetch addr=%h got %h/%b/%b want %h/%b/%b",
                             e.addr, q128, mis128, oor128, e.q, e.mis, e.oor);
                end
            end
        end
        addr128 = 8'h05;
        #1;
        n_cmp++;
        if (q128 !== 16'h20BA || mis128 !== 1'b1) begin
            n_bad++;
            $display("FAIL small_q05 got q=%h mis=%b want 20ba/1", q128, mis128);
        end
    endtask

    task automatic test_full();
        @(posedge CLK);
        #1;
        reload128 = 1'b1;
        cnt128 = 0;
        run128 = 1'b0;
        @(posedge CLK);
        #1;
        reload128 = 1'b0;
        n_cmp++;
        if (rr128 !== 1'b0 || wc128 !== 8'd0 || ld128.LD_READY !== 1'b1) begin
            n_bad++;
            $display("FAIL full_reload got rr=%b wc=%0d rdy=%b want 0/0/1",
                     rr128, wc128, ld128.LD_READY);
        end
        for (int i = 0; i < 128; i++) begin
            load_word(1'b1, 16'($urandom), 1'b0);
            if (i == 126) begin
                n_cmp++;
                if (rr128 !== 1'b0 || wc128 !== 8'd127 || ld128.LD_READY !== 1'b1) begin
                    n_bad++;
                    $display("FAIL full_127 got rr=%b wc=%0d rdy=%b want 0/127/1",
                             rr128, wc128, ld128.LD_READY);
                end
            end
        end
        n_cmp++;
        if (rr128 !== 1'b1 || wc128 !== 8'd128 || ld128.LD_READY !== 1'b0) begin
            n_bad++;
            $display("FAIL full_128 got rr=%b wc=%0d rdy=%b want 1/128/0",
                     rr128, wc128, ld128.LD_READY);
        end
        load_word(1'b1, ~m128[0], 1'b0);
        n_cmp++;
        if (wc128 !== 8'd128) begin
            n_bad++; $display("FAIL full_stray_wc got %0d want 128", wc128);
        end
        begin
            logic [7:0] al [5];
            al = '{8'h00, 8'hFE, 8'h80, 8'h81, 8'h7E};
            foreach (al[i]) begin
                exp_t e;
                drive_fetch(1'b1, al[i]);
                #1;
                e = exp_q.pop_front();
                n_cmp++;
                if (q128 !== e.q || mis128 !== e.mis || oor128 !== e.oor) begin
                    n_bad++;
                    $display("FAIL full_fetch addr=%h got %h/%b/%b want %h/%b/%b",
                             e.addr, q128, mis128, oor128, e.q, e.mis, e.oor);
                end
            end
        end
    endtask

    task automatic test_oor();
        for (int i = 0; i < 64; i++) begin
            load_word(1'b0, 16'($urandom) | 16'h0001, 1'b0);
        end
        n_cmp++;
        if (rr64 !== 1'b1 || wc64 !== 7'd64 || ld64.LD_READY !== 1'b0) begin
            n_bad++;
            $display("FAIL oor_full got rr=%b wc=%0d rdy=%b want 1/64/0",
                     rr64, wc64, ld64.LD_READY);
        end
        addr64 = 8'h80;
        #1;
        n_cmp++;
        if (oor64 !== 1'b1 || q64 !== 16'h0000) begin
            n_bad++;
            $display("FAIL oor_80 got oor=%b q=%h want 1/0000", oor64, q64);
        end
        begin
            logic [7:0] al [5];
            al = '{8'h7E, 8'hFF, 8'h00, 8'h41, 8'hC0};
            foreach (al[i]) begin
                exp_t e;
                drive_fetch(1'b0, al[i]);
                #1;
                e = exp_q.pop_front();
                n_cmp++;
                if (q64 !== e.q || mis64 !== e.mis || oor64 !== e.oor) begin
                    n_bad++;
                    $display("FAIL oor_fetch addr=%h got %h/%b/%b want %h/%b/%b",
                             e.addr, q64, mis64, oor64, e.q, e.mis, e.oor);
                end
            end
        end
    endtask

    task automatic test_reload();
        @(posedge CLK);
        #1;
        reload128 = 1'b1;
        ld128.LD_VALID = 1'b1;
        ld128.LD_DATA  = 16'hBEEF;
        cnt128 = 0;
        run128 = 1'b0;
        @(posedge CLK);
        #1;
        n_cmp++;
        if (rr128 !== 1'b0 || wc128 !== 8'd0 || ld128.LD_READY !== 1'b1) begin
            n_bad++;
            $display("FAIL reload_run got rr=%b wc=%0d rdy=%b want 0/0/1",
                     rr128, wc128, ld128.LD_READY);
        end
        ld128.LD_DATA = 16'hCAFE;
        @(posedge CLK);
        #1;
        reload128 = 1'b0;
        ld128.LD_VALID = 1'b0;
        n_cmp++;
        if (wc128 !== 8'd0 || rr128 !== 1'b0) begin
            n_bad++;
            $display("FAIL reload_load got wc=%0d rr=%b want 0/0", wc128, rr128);
        end
        load_word(1'b1, 16'h1234, 1'b1);
        n_cmp++;
        if (wc128 !== 8'd1 || rr128 !== 1'b1) begin
            n_bad++;
            $display("FAIL reload_one got wc=%0d rr=%b want 1/1", wc128, rr128);
        end
        addr128 = 8'h00;
        #1;
        n_cmp++;
        if (q128 !== 16'h1234) begin
            n_bad++; $display("FAIL reload_q0 got %h want 1234", q128);
        end
        drive_fetch(1'b1, 8'h02);
        #1;
        begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            if (q128 !== e.q || q128 !== 16'h0000) begin
                n_bad++; $display("FAIL reload_q2 got %h want %h", q128, e.q);
            end
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] w [5];
        w = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555};
        @(posedge CLK);
        #1;
        reload128 = 1'b1;
        @(posedge CLK);
        #1;
        reload128 = 1'b0;
        cnt128 = 0;
        run128 = 1'b0;
        load_word(1'b1, 16'hAAAA, 1'b0);
        load_word(1'b1, 16'hBBBB, 1'b0);
        #3;
        RESET = 1'b1;
        cnt128 = 0; run128 = 1'b0;
        cnt64  = 0; run64  = 1'b0;
        #1;
        n_cmp++;
        if (wc128 !== 8'd0 || ld128.LD_READY !== 1'b1 || rr128 !== 1'b0) begin
            n_bad++;
            $display("FAIL async_rst got wc=%0d rdy=%b rr=%b want 0/1/0",
                     wc128, ld128.LD_READY, rr128);
        end
        #2;
        RESET = 1'b0;
        foreach (w[i]) load_word(1'b1, w[i], i == 4);
        n_cmp++;
        if (wc128 !== 8'd5 || rr128 !== 1'b1) begin
            n_bad++;
            $display("FAIL async_reload got wc=%0d rr=%b want 5/1", wc128, rr128);
        end
        for (int i = 0; i < 6; i++) begin
            exp_t e;
            drive_fetch(1'b1, 8'(2 * i));
            #1;
            e = exp_q.pop_front();
            n_cmp++;
            if (q128 !== e.q || mis128 !== e.mis || oor128 !== e.oor) begin
                n_bad++;
                $display("FAIL async_fetch addr=%h got %h/%b/%b want %h/%b/%b",
                         e.addr, q128, mis128, oor128, e.q, e.mis, e.oor);
            end
        end
    endtask

    initial begin
        reload128 = 1'b0;
        reload64  = 1'b0;
        ld128.LD_VALID = 1'b0; ld128.LD_DATA = '0; ld128.LD_LAST = 1'b0;
        ld64.LD_VALID  = 1'b0; ld64.LD_DATA  = '0; ld64.LD_LAST  = 1'b0;
        cnt128 = 0; cnt64 = 0;
        run128 = 1'b0; run64 = 1'b0;
        test_reset();
        test_small_load();
        test_full();
        test_oor();
        test_reload();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
